ad5543_rx: RTL
==============

# ad5543_rx

- Serial-to-parallel receiver for the AD5543 three-wire DAC interface (sclk, sdi, cs_n): the responder end of that link.
- Oversamples all three lines in the `aclk` domain and shifts sdi in MSB-first on every sclk rising edge while cs_n is low.
- On cs_n deassertion it delivers a complete `DW`-bit word on a valid/ready output, or flags a framing error.
- Used as a loopback checker and DAC model in the transmit system, and as the input stage for boards driven by an external AD5543-style master.

## Interface
Parameters:
- `DW`, 16, word width and exact number of sclk rising edges per valid frame.
- `SYNC_STAGES`, 2, synchronizer flops on each serial input; minimum 2.

Ports:
- `aclk` input 1: system clock; all logic on the rising edge.
- `areset` input 1: reset, asynchronous, active-high.
- `sclk` input 1: serial clock, asynchronous to `aclk`.
- `sdi` input 1: serial data, MSB first.
- `cs_n` input 1: frame select, active low.
- `m_data` output DW: received word.
- `m_valid` output 1: `m_data` holds an unconsumed word.
- `m_ready` input 1: consumer accepts the word when `m_valid && m_ready`.
- `frame_err` output 1: one-cycle pulse when a frame ends with a bit count other than `DW`.
- `overrun` output 1: one-cycle pulse when a new word overwrites an unconsumed one.

## Operation
- `sclk`, `sdi` and `cs_n` each pass through `SYNC_STAGES` flops. Edges are detected on the last stage against a one-cycle-delayed copy.
- The sdi bit is taken from the same synchronizer stage as the detected sclk rise, so the three lines stay aligned.
- State machine, one state active at a time:
  - WAIT_IDLE: entered on reset. Go to IDLE once synchronized `cs_n` = 1. This discards any frame already in progress at reset release.
  - IDLE: on synchronized `cs_n` falling, clear the shift register and bit counter, then go to SHIFT.
  - SHIFT: on each sclk rise, shift the register left with sdi in at the LSB, and increment the counter. The counter saturates at `DW`+1.
  - SHIFT, on synchronized `cs_n` rising:
    - If count == `DW`: load `m_data` and set `m_valid`.
    - Otherwise: pulse `frame_err`; `m_data` and `m_valid` are unchanged.
    - In both cases, go to IDLE.
- An sclk rise in the same cycle as the cs_n rise is ignored.
- sclk edges while in IDLE or WAIT_IDLE are ignored.
- Output handshake:
  - `m_valid` clears on the cycle after `m_valid && m_ready`.
  - If a word completes while `m_valid` = 1 and no handshake is occurring that cycle:
    - the new word replaces `m_data`;
    - `m_valid` stays 1;
    - `overrun` pulses.
  - Completion and handshake in the same cycle: the new word loads, `m_valid` stays 1, no `overrun`.
- Reset values: `m_data` = 0, `m_valid` = 0, `frame_err` = 0, `overrun` = 0, state WAIT_IDLE, counter 0.

## Timing
- Input constraints:
  - sclk high and low phases each ≥ 2 `aclk` periods.
  - sdi stable ≥ 1 `aclk` period before and after each sclk rise.
  - cs_n high ≥ 2 `aclk` periods between frames.
- Latency, from the first `aclk` edge that samples `cs_n` = 1 to `m_valid` (or `frame_err`) high: `SYNC_STAGES` + 1 cycles. That is 3 cycles at the default.
- `frame_err` and `overrun` are high for exactly one `aclk` cycle.
- Throughput: one word per frame, no dead cycles beyond the cs_n high time.
- Asynchronous reset mid-frame: all outputs go to reset values immediately, with no glitch of `m_valid`. The next accepted frame is the first one that starts after cs_n is seen high.

## Structure
- Package `ad5543_pkg`:
  - state enum `rx_state_t` (WAIT_IDLE, IDLE, SHIFT);
  - default constants `AD5543_DW` = 16 and `AD5543_SYNC` = 2.
- Sub-module `serial_in_sync`: a `SYNC_STAGES`-deep synchronizer plus rise/fall pulse detector. Instantiated once per serial line.
- The top level holds the FSM, shift register, counter and output register.

## Test plan
- Frame 0xA5C3, sclk = `aclk`/4, `m_ready` = 1 → `m_valid` high for one cycle, 3 cycles after cs_n rise, with `m_data` = 0xA5C3; no `frame_err`.
- 15-bit frame, then 17-bit frame → one `frame_err` pulse for each; `m_valid` stays 0.
- Two back-to-back frames 0x1234 and 0xFFFF with `m_ready` = 0 → one `overrun` pulse, `m_data` = 0xFFFF, `m_valid` = 1. Raising `m_ready` clears `m_valid` the next cycle.
- Reset asserted after 8 bits of frame 0x00FF, released while cs_n is still low → no word and no error for that frame; the following frame 0x8001 is received correctly.
- 100 random frames from the existing AD5543 transmitter looped back (sclk, sdi, cs_n wired directly) → every received word equals the transmitted word, zero errors.

Source files
------------

// File: rtl/ad5543_pkg.sv
// Shared types and defaults for the AD5543 serial receiver.
package ad5543_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } rx_state_t;

    localparam int AD5543_DW   = 16;
    localparam int AD5543_SYNC = 2;

endpackage

// File: rtl/serial_in_sync.sv
// Multi-flop synchronizer for one asynchronous serial line, with registered
// level and rise/fall pulses that are mutually aligned.
module serial_in_sync #(
    parameter int STAGES = 2
) (
    input  logic aclk,
    input  logic areset,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // Synchronizer chain plus edge detection on the last stage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sync_q <= {STAGES{1'b0}};
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    // prev_q carries the level that the registered pulses refer to, so a
    // data line's level_o lines up with a clock line's rise_o.
    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ad5543_rx.sv
// AD5543 three-wire responder: oversampled serial shift-in, framed by cs_n,
// delivering DW-bit words on a valid/ready output.
module ad5543_rx
    import ad5543_pkg::*;
#(
    parameter int DW          = AD5543_DW,
    parameter int SYNC_STAGES = AD5543_SYNC
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          sclk,
    input  logic          sdi,
    input  logic          cs_n,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          frame_err,
    output logic          overrun
);

    localparam int CW = $clog2(DW + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DW);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DW + 1);

    logic sclk_rise_s, sclk_fall_s, sclk_lvl_s;
    logic sdi_lvl_s, sdi_rise_s, sdi_fall_s;
    logic cs_lvl_s, cs_rise_s, cs_fall_s;
    logic unused_s;

    serial_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .aclk(aclk), .areset(areset), .din_i(sclk),
        .level_o(sclk_lvl_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    serial_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .aclk(aclk), .areset(areset), .din_i(sdi),
        .level_o(sdi_lvl_s), .rise_o(sdi_rise_s), .fall_o(sdi_fall_s)
    );

    serial_in_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .aclk(aclk), .areset(areset), .din_i(cs_n),
        .level_o(cs_lvl_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
    );

    assign unused_s = ^{sclk_fall_s, sclk_lvl_s, sdi_rise_s, sdi_fall_s};

    rx_state_t     state_q;
    logic [DW-1:0] shreg_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] m_data_q;
    logic          m_valid_q;
    logic          frame_err_q;
    logic          overrun_q;

    // Frame FSM, shift register, bit counter and registered outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= WAIT_IDLE;
            shreg_q     <= {DW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            m_data_q    <= {DW{1'b0}};
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                WAIT_IDLE: begin
                    if (cs_lvl_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_fall_s) begin
                        shreg_q <= {DW{1'b0}};
                        cnt_q   <= {CW{1'b0}};
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Frame end takes priority over a coincident sclk rise.
                    if (cs_rise_s) begin
                        if (cnt_q == CNT_FULL) begin
                            m_data_q  <= shreg_q;
                            m_valid_q <= 1'b1;
                            overrun_q <= m_valid_q & ~m_ready;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (sclk_rise_s) begin
                        shreg_q <= {shreg_q[DW-2:0], sdi_lvl_s};
                        if (cnt_q != CNT_SAT) begin
                            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_IDLE;
                end
            endcase
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
